branch_predictor: RTL and testbench

- Parametrised branch prediction unit: the next generation of the ID-stage branch resolver.
- Sits beside the IF stage. Looks up the fetch PC in a direct-mapped branch target buffer (BTB) of 2-bit saturating counters and returns a predicted direction and target in the same cycle.
- Trained from ID-stage branch resolution one cycle later. Flags mispredictions with a redirect PC and keeps performance counters.

---
 rtl/bp_pkg.sv | 37 +++
 rtl/branch_predictor_sat_counter.sv | 31 +++
 rtl/branch_predictor.sv | 141 ++++++++++++++
 tb/tb_branch_predictor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types, branch-type codes and saturating-counter helpers for the branch predictor.
package bp_pkg;

  localparam int unsigned BP_TAG_W = 10;
  localparam int unsigned BP_CNT_W = 2;

  // Branch type codes, mirrored from common.vh
  localparam logic [2:0] B_NONE = 3'd0;
  localparam logic [2:0] B_EQNE = 3'd1;
  localparam logic [2:0] B_LTGE = 3'd2;
  localparam logic [2:0] B_JUMP = 3'd3;
  localparam logic [2:0] B_JREG = 3'd4;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_CNT_W-1:0] cnt;
    logic [31:0]         target;
  } btb_entry_t;

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned v);
    return (v == 0) ? 0 : v - 1;
  endfunction

  function automatic logic is_cond_type(input logic [2:0] t);
    return (t == B_EQNE) || (t == B_LTGE);
  endfunction

  function automatic logic is_jump_type(input logic [2:0] t);
    return (t == B_JUMP) || (t == B_JREG);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-value logic for one BTB saturating counter; force_max beats init beats inc beats dec.
module sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             inc,
  input  logic             dec,
  input  logic             force_max,
  input  logic             init,
  output logic [CNT_W-1:0] cnt_c
);

  localparam int unsigned MAX_V  = (1 << CNT_W) - 1;
  localparam int unsigned WEAK_V = 1 << (CNT_W - 1);

  always_comb begin
    cnt_c = cnt_i;
    if (force_max) begin
      cnt_c = CNT_W'(MAX_V);
    end else if (init) begin
      cnt_c = CNT_W'(WEAK_V);
    end else if (inc) begin
      cnt_c = CNT_W'(sat_inc(32'(cnt_i), MAX_V));
    end else if (dec) begin
      cnt_c = CNT_W'(sat_dec(32'(cnt_i)));
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit style counters: same-cycle lookup for IF,
// one-cycle-later training from ID resolution, misprediction redirect and perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 10,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [2:0]        upd_branch_type,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_LSB = IDX_W + 2;

  // Flat register table so the lookup can be purely combinational
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];
  logic [CNT_W-1:0] cnt_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];

  logic [PERF_W-1:0] perf_branches_q, perf_branches_d;
  logic [PERF_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

  logic [IDX_W-1:0] look_idx_c;
  logic [TAG_W-1:0] look_tag_c;
  logic [IDX_W-1:0] upd_idx_c;
  logic [TAG_W-1:0] upd_tag_c;
  logic             upd_hit_c;
  logic             upd_cond_c;
  logic             upd_jump_c;
  logic             wr_en_c;
  logic [CNT_W-1:0] cnt_nxt_c;

  assign look_idx_c = if_pc[TAG_LSB-1:2];
  assign look_tag_c = if_pc[TAG_LSB +: TAG_W];
  assign upd_idx_c  = upd_pc[TAG_LSB-1:2];
  assign upd_tag_c  = upd_pc[TAG_LSB +: TAG_W];

  // Lookup reads the pre-update table: no bypass from the training path
  always_comb begin
    pred_hit    = valid_q[look_idx_c] && (tag_q[look_idx_c] == look_tag_c);
    pred_taken  = pred_hit && cnt_q[look_idx_c][CNT_W-1];
    pred_target = pred_hit ? target_q[look_idx_c] : if_pc + 32'd8;
  end

  always_comb begin
    upd_hit_c  = valid_q[upd_idx_c] && (tag_q[upd_idx_c] == upd_tag_c);
    upd_cond_c = is_cond_type(upd_branch_type);
    upd_jump_c = is_jump_type(upd_branch_type);
    wr_en_c    = upd_valid && (upd_cond_c || upd_jump_c) && (upd_hit_c || upd_taken);
  end

  sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
    .cnt_i     (cnt_q[upd_idx_c]),
    .inc       (upd_hit_c && upd_cond_c && upd_taken),
    .dec       (upd_hit_c && upd_cond_c && !upd_taken),
    .force_max (upd_jump_c),
    .init      (!upd_hit_c && upd_cond_c),
    .cnt_c     (cnt_nxt_c)
  );

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = 32'd0;
    if (upd_valid) begin
      mispredict  = (upd_taken != upd_pred_taken) ||
                    (upd_taken && (upd_target != upd_pred_target));
      redirect_pc = upd_taken ? upd_target : upd_pc + 32'd8;
    end
  end

  // Next table and counter state; a miss only reaches here when taken (allocation)
  always_comb begin
    valid_d            = valid_q;
    tag_d              = tag_q;
    cnt_d              = cnt_q;
    target_d           = target_q;
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (wr_en_c) begin
      valid_d[upd_idx_c] = 1'b1;
      tag_d[upd_idx_c]   = upd_tag_c;
      cnt_d[upd_idx_c]   = cnt_nxt_c;
      if (upd_taken || upd_jump_c) begin
        target_d[upd_idx_c] = upd_target;
      end
    end
    if (upd_valid) begin
      perf_branches_d = perf_branches_q + PERF_W'(1);
    end
    if (mispredict) begin
      perf_mispredicts_d = perf_mispredicts_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        cnt_q[i]    <= '0;
        target_q[i] <= 32'd0;
      end
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      cnt_q              <= cnt_d;
      target_q           <= target_d;
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (64 entries, 4-bit perf counters).
module tb_branch_predictor;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_branch_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  perf_branches;
  logic [3:0]  perf_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_br = 4'd0;
  logic [3:0] exp_mp = 4'd0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .TAG_W(10), .CNT_W(2), .PERF_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_branch_type  (upd_branch_type),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] tgt);
    if_pc = pc;
    #1;
    check({tag, ".hit"}, 32'(pred_hit), 32'(hit));
    check({tag, ".taken"}, 32'(pred_taken), 32'(taken));
    check({tag, ".target"}, pred_target, tgt);
  endtask

  task automatic chk_perf(input string tag);
    check({tag, ".perf_br"}, 32'(perf_branches), 32'(exp_br));
    check({tag, ".perf_mp"}, 32'(perf_mispredicts), 32'(exp_mp));
  endtask

  task automatic upd(input string tag, input logic [2:0] ty, input logic [31:0] pc,
                     input logic tk, input logic [31:0] tgt, input logic ptk,
                     input logic [31:0] ptgt, input logic mp, input logic [31:0] redir);
    @(negedge clk);
    upd_valid       = 1'b1;
    upd_branch_type = ty;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    #1;
    check({tag, ".mispredict"}, 32'(mispredict), 32'(mp));
    check({tag, ".redirect"}, redirect_pc, redir);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    exp_br++;
    if (mp) exp_mp++;
  endtask

  initial begin
    // Reset with a live update that must be ignored
    rst_n = 1'b0; if_pc = 32'h0;
    upd_valid = 1'b1; upd_pc = 32'h0040_0020; upd_branch_type = B_EQNE;
    upd_taken = 1'b1; upd_target = 32'h0040_0100;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; upd_valid = 1'b0;
    look("reset", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0018);
    look("reset_no_alloc", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0028);
    check("idle.mispredict", 32'(mispredict), 32'd0);
    check("idle.redirect", redirect_pc, 32'd0);
    chk_perf("reset");

    // Allocate weakly taken, then strengthen
    if_pc = 32'h0040_0020;
    upd("alloc", B_EQNE, 32'h0040_0020, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    look("alloc", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0100);
    chk_perf("alloc");
    upd("strengthen", B_EQNE, 32'h0040_0020, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0100);

    // Decay 11 -> 10 -> 01 -> 00 -> 00, then +1 -> 01
    upd("decay1", B_EQNE, 32'h0040_0020, 1'b0, 32'h0, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0028);
    look("decay1", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0100);
    upd("decay2", B_EQNE, 32'h0040_0020, 1'b0, 32'h0, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0028);
    look("decay2", 32'h0040_0020, 1'b1, 1'b0, 32'h0040_0100);
    upd("decay3", B_LTGE, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0040_0028);
    look("decay3", 32'h0040_0020, 1'b1, 1'b0, 32'h0040_0100);
    upd("floor", B_EQNE, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0040_0028);
    upd("from_floor", B_EQNE, 32'h0040_0020, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    look("from_floor", 32'h0040_0020, 1'b1, 1'b0, 32'h0040_0100);
    chk_perf("decay");

    // Alias eviction at the same index, different tag
    upd("alias", B_EQNE, 32'h0040_0120, 1'b1, 32'h0040_0200, 1'b0, 32'h0, 1'b1, 32'h0040_0200);
    look("evicted", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0028);
    look("alias", 32'h0040_0120, 1'b1, 1'b1, 32'h0040_0200);

    // Not-taken miss allocates nothing
    upd("nt_miss", B_EQNE, 32'h0040_0060, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0040_0068);
    look("nt_miss", 32'h0040_0060, 1'b0, 1'b0, 32'h0040_0068);

    // JR allocate, then retarget with same-cycle lookup of the old entry
    upd("jr1", B_JREG, 32'h0040_0040, 1'b1, 32'h8000_1000, 1'b0, 32'h0, 1'b1, 32'h8000_1000);
    look("jr1", 32'h0040_0040, 1'b1, 1'b1, 32'h8000_1000);
    @(negedge clk);
    if_pc = 32'h0040_0040;
    upd_valid = 1'b1; upd_branch_type = B_JREG; upd_pc = 32'h0040_0040;
    upd_taken = 1'b1; upd_target = 32'h8000_2000;
    upd_pred_taken = 1'b1; upd_pred_target = 32'h8000_1000;
    #1;
    check("collide.target", pred_target, 32'h8000_1000);
    check("collide.mispredict", 32'(mispredict), 32'd1);
    @(posedge clk);
    #1;
    upd_valid = 1'b0; exp_br++; exp_mp++;
    look("jr2", 32'h0040_0040, 1'b1, 1'b1, 32'h8000_2000);

    // Unknown type: counted but no table change
    upd("unknown", 3'd7, 32'h0040_0080, 1'b1, 32'h0000_1234, 1'b0, 32'h0, 1'b1, 32'h0000_1234);
    look("unknown", 32'h0040_0080, 1'b0, 1'b0, 32'h0040_0088);

    // Jump keeps counter at max: one not-taken step still predicts taken
    upd("jump_hit", B_JUMP, 32'h0040_0040, 1'b1, 32'h8000_2000, 1'b1, 32'h8000_2000, 1'b0, 32'h8000_2000);
    upd("after_max", B_EQNE, 32'h0040_0040, 1'b0, 32'h0, 1'b1, 32'h8000_2000, 1'b1, 32'h0040_0048);
    look("after_max", 32'h0040_0040, 1'b1, 1'b1, 32'h8000_2000);

    // Reach 17 updates: 4-bit perf_branches wraps to 1
    for (int i = 0; i < 3; i++) begin
      upd("fill", B_EQNE, 32'h0040_0060, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0040_0068);
    end
    check("wrap.perf_br_const", 32'(perf_branches), 32'd1);
    check("wrap.perf_mp_const", 32'(perf_mispredicts), 32'd9);
    chk_perf("wrap");

    // Reset during a training update drops it and clears everything
    @(negedge clk);
    rst_n = 1'b0;
    upd_valid = 1'b1; upd_branch_type = B_JUMP; upd_pc = 32'h0040_0300;
    upd_taken = 1'b1; upd_target = 32'h0000_4000;
    @(posedge clk);
    #1;
    rst_n = 1'b1; upd_valid = 1'b0;
    exp_br = 4'd0; exp_mp = 4'd0;
    look("mid_reset_drop", 32'h0040_0300, 1'b0, 1'b0, 32'h0040_0308);
    look("mid_reset_clear", 32'h0040_0040, 1'b0, 1'b0, 32'h0040_0048);
    chk_perf("mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
